// File: rtl/gray_seq_pkg.sv
// Shared types and helpers for the gray-code sequencer and its datapath.
// The datapath consumers also use bin2gray, so it stays width-agnostic.
package gray_seq_pkg;

    localparam int DEF_WIDTH  = 4;
    localparam int GRAY_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Callers cast the result down to their own width.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_seq_ctrl_if.sv
// Valid/ready code stream carrying a coherent binary/gray pair.
interface gray_seq_ctrl_if #(parameter int WIDTH = 4);

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_bin;
    logic [WIDTH-1:0] out_gray;

    modport master (output out_valid, output out_bin, output out_gray, input out_ready);
    modport slave  (input out_valid, input out_bin, input out_gray, output out_ready);

endinterface

// File: rtl/gray_seq_step.sv
// Next-count logic: steps toward the end value, reloading the start value once it is reached.
module gray_seq_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] limit,
    input  logic             mode_dn,
    output logic [WIDTH-1:0] count_nxt,
    output logic             at_end
);

    always_comb begin
        at_end = mode_dn ? (count == '0) : (count == limit);
        if (at_end) begin
            count_nxt = mode_dn ? limit : '0;
        end else begin
            count_nxt = mode_dn ? (count - WIDTH'(1)) : (count + WIDTH'(1));
        end
    end

endmodule

// File: rtl/gray_seq_ctrl.sv
// Sequencer walking a binary count between 0 and limit, presenting each
// step as a registered binary/gray pair on a valid/ready stream.
module gray_seq_ctrl
    import gray_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode_dn,
    input  logic             cont,
    input  logic [WIDTH-1:0] limit,
    output logic             busy,
    output logic             done,
    gray_seq_ctrl_if.master  stream
);

    state_t           state, state_d;
    logic             mode_q, cont_q;
    logic [WIDTH-1:0] limit_q;
    logic             load, adv;
    logic [WIDTH-1:0] count_d, step_nxt;
    logic             at_end;

    logic             vld_p1;
    logic [WIDTH-1:0] bin_p1, gray_p1;

    gray_seq_step #(.WIDTH(WIDTH)) u_step (
        .count     (bin_p1),
        .limit     (limit_q),
        .mode_dn   (mode_q),
        .count_nxt (step_nxt),
        .at_end    (at_end)
    );

    always_comb begin
        state_d = state;
        load    = 1'b0;
        adv     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                // stop wins over a same-cycle handshake: the transfer happens but the count holds
                if (stop) begin
                    state_d = IDLE;
                end else if (vld_p1 && stream.out_ready) begin
                    if (at_end && !cont_q) state_d = DONE;
                    else                   adv     = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        count_d = bin_p1;
        if (load)     count_d = mode_dn ? limit : '0;
        else if (adv) count_d = step_nxt;
    end

    // p0 -> p1: state, config latches and the registered output pair
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            mode_q  <= 1'b0;
            cont_q  <= 1'b0;
            limit_q <= '0;
            bin_p1  <= '0;
            gray_p1 <= '0;
            vld_p1  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            if (load) begin
                mode_q  <= mode_dn;
                cont_q  <= cont;
                limit_q <= limit;
            end
            bin_p1  <= count_d;
            gray_p1 <= WIDTH'(bin2gray(GRAY_MAX_W'(count_d)));
            vld_p1  <= (state_d == RUN);
            busy    <= (state_d == RUN);
            done    <= (state_d == DONE);
        end
    end

    assign stream.out_valid = vld_p1;
    assign stream.out_bin   = bin_p1;
    assign stream.out_gray  = gray_p1;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Bench for gray_seq_ctrl: directed and randomized sequences against an
// index-based reference model of the code sequence.
module tb_gray_seq_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0, stop = 1'b0, mode_dn = 1'b0, cont = 1'b0;
    logic [W-1:0] limit = '0;
    logic         busy, done;

    gray_seq_ctrl_if #(.WIDTH(W)) sif ();

    gray_seq_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .mode_dn (mode_dn),
        .cont    (cont),
        .limit   (limit),
        .busy    (busy),
        .done    (done),
        .stream  (sif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: position k along the sequence 0..lim (reversed when counting down)
    bit m_run = 1'b0, m_done = 1'b0, m_dn = 1'b0, m_cont = 1'b0;
    int m_k = 0, m_lim = 0;

    logic [W-1:0] xq[$];
    logic [W-1:0] bq[$];

    function automatic int exp_bin();
        return m_dn ? (m_lim - m_k) : m_k;
    endfunction

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("out_valid", 32'(sif.out_valid), 32'(m_run));
        check("busy", 32'(busy), 32'(m_run));
        check("done", 32'(done), 32'(m_done));
        if (m_run) begin
            check("out_bin", 32'(sif.out_bin), 32'(exp_bin()));
            check("out_gray", 32'(sif.out_gray), 32'(gray_of(exp_bin())));
        end
    endtask

    task automatic cycle(input bit st, input bit sp, input bit md, input bit ct,
                         input int lm, input bit rdy);
        bit idle;
        start         = st;
        stop          = sp;
        mode_dn       = md;
        cont          = ct;
        limit         = W'(lm);
        sif.out_ready = rdy;
        if (sif.out_valid === 1'b1 && rdy) begin
            xq.push_back(sif.out_gray);
            bq.push_back(sif.out_bin);
        end
        @(posedge clk);
        idle   = !m_run && !m_done;
        m_done = 1'b0;
        if (idle) begin
            if (st && !sp) begin
                m_run  = 1'b1;
                m_k    = 0;
                m_dn   = md;
                m_cont = ct;
                m_lim  = lm;
            end
        end else if (m_run) begin
            if (sp) begin
                m_run = 1'b0;
            end else if (rdy) begin
                if (m_k == m_lim) begin
                    if (m_cont) m_k = 0;
                    else begin
                        m_run  = 1'b0;
                        m_done = 1'b1;
                    end
                end else begin
                    m_k++;
                end
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #1;
        m_run  = 1'b0;
        m_done = 1'b0;
        m_k    = 0;
        check("rst_valid", 32'(sif.out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_bin", 32'(sif.out_bin), 0);
        check("rst_gray", 32'(sif.out_gray), 0);
        start = 1'b0;
        stop  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // rmode: 0 ready held high, 1 ready toggling, 2 ready random
    task automatic run_seq(input bit md, input bit ct, input int lm, input int rmode,
                           input int stop_at, input bit scramble, input int maxc);
        xq.delete();
        bq.delete();
        cycle(1'b1, 1'b0, md, ct, lm, 1'b1);
        for (int i = 0; i < maxc && (m_run || m_done); i++) begin
            bit rdy, st, m2, c2;
            int l2;
            rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? bit'(i % 2 == 0) : bit'($urandom_range(0, 1));
            st = 1'b0; m2 = md; c2 = ct; l2 = lm;
            if (scramble) begin
                st = bit'($urandom_range(0, 1));
                m2 = bit'($urandom_range(0, 1));
                c2 = bit'($urandom_range(0, 1));
                l2 = int'($urandom_range(0, 15));
            end
            cycle(st, bit'(i == stop_at), m2, c2, l2, rdy);
        end
        check("seq_end_valid", 32'(sif.out_valid), 0);
        check("seq_end_busy", 32'(busy), 0);
    endtask

    initial begin
        logic [W-1:0] g_up5 [6];
        logic [W-1:0] g_dn3 [4];
        g_up5 = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111};
        g_dn3 = '{4'b0010, 4'b0011, 4'b0001, 4'b0000};

        sif.out_ready = 1'b0;
        rst = 1'b0;
        #100;
        check("por_valid", 32'(sif.out_valid), 0);
        check("por_bin", 32'(sif.out_bin), 0);
        check("por_gray", 32'(sif.out_gray), 0);
        rst = 1'b1;
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 5, 1'b1);
        check("idle_bin", 32'(sif.out_bin), 0);
        check("idle_gray", 32'(sif.out_gray), 0);

        // up to 5, single pass, full throughput
        run_seq(1'b0, 1'b0, 5, 0, -1, 1'b0, 50);
        check("up5_count", 32'(xq.size()), 6);
        for (int i = 0; i < 6; i++) begin
            check("up5_gray", 32'(xq[i]), 32'(g_up5[i]));
            check("up5_bin", 32'(bq[i]), 32'(i));
        end

        // down from 3 with ready toggling
        run_seq(1'b1, 1'b0, 3, 1, -1, 1'b0, 50);
        check("dn3_count", 32'(xq.size()), 4);
        for (int i = 0; i < 4; i++) begin
            check("dn3_gray", 32'(xq[i]), 32'(g_dn3[i]));
            check("dn3_bin", 32'(bq[i]), 32'(3 - i));
        end

        // continuous up to 15, stop mid-run after the wrap
        run_seq(1'b0, 1'b1, 15, 0, 20, 1'b0, 60);
        check("wrap_count", 32'(xq.size()), 21);
        check("wrap_g15", 32'(xq[15]), 32'(4'b1000));
        check("wrap_g0", 32'(xq[16]), 0);

        // limit 0: single code, then done
        run_seq(1'b0, 1'b0, 0, 0, -1, 1'b0, 10);
        check("lim0_count", 32'(xq.size()), 1);
        check("lim0_gray", 32'(xq[0]), 0);
        run_seq(1'b1, 1'b1, 0, 2, 6, 1'b0, 20);

        // start and stop together in IDLE
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 5, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 5, 1'b1);

        // start and config churn during RUN
        run_seq(1'b0, 1'b0, 7, 2, -1, 1'b1, 100);
        run_seq(1'b1, 1'b0, 15, 2, -1, 1'b1, 100);

        // reset while the third code is presented, then a fresh start
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 10, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 10, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 10, 1'b1);
        check("pre_rst_bin", 32'(sif.out_bin), 2);
        apply_reset();
        run_seq(1'b0, 1'b0, 2, 0, -1, 1'b0, 20);
        check("post_rst_first", 32'(bq[0]), 0);

        for (int n = 0; n < 30; n++) begin
            bit md, ct, sc;
            int lm, sa;
            md = bit'($urandom_range(0, 1));
            ct = bit'($urandom_range(0, 1));
            sc = bit'($urandom_range(0, 1));
            lm = int'($urandom_range(0, 15));
            if (ct) sa = int'($urandom_range(0, 40));
            else    sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
            run_seq(md, ct, lm, 2, sa, sc, 200);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_seq_ctrl.md
# gray_seq_ctrl

- Sequencer for the binary-to-gray counter datapath.
- On a start command it walks a binary count between 0 and a programmable limit, in either direction, either once or wrapping.
- Each step is presented as a registered binary/gray pair on a valid/ready output stream, and the count advances only when the consumer accepts.
- Sits between the control/configuration logic and any gray-code consumer, for example a CDC pointer or encoder test path.

## Interface
- WIDTH, 4, counter and code width in bits (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a sequence; honoured only in IDLE
- stop  in  1  abort the running sequence; level or pulse
- mode_dn  in  1  0 = count up, 1 = count down; sampled at accepted start
- cont  in  1  1 = wrap forever until stop; sampled at accepted start
- limit  in  WIDTH  sequence bound; sampled at accepted start
- out_valid  out  1  out_bin/out_gray hold a code
- out_ready  in  1  consumer accepts the current code
- out_bin  out  WIDTH  current binary count
- out_gray  out  WIDTH  out_bin ^ (out_bin >> 1)
- busy  out  1  state is RUN
- done  out  1  one-cycle pulse when a non-continuous sequence completes

## Operation
- States:
  - IDLE: outputs quiet, waiting for start.
  - RUN: presenting codes.
  - DONE: single cycle.
- IDLE → RUN on start=1 && stop=0:
  - Latch mode_dn, cont and limit into internal registers.
  - Load the count with 0 (up) or limit (down).
- RUN, handshake (out_valid && out_ready), count ≠ end value: step the count by +1 (up) or −1 (down). The end value is limit (up) or 0 (down).
- RUN, handshake at end value, cont=0: go to DONE.
- RUN, handshake at end value, cont=1: reload, 0 after limit (up) or limit after 0 (down). Stay in RUN; done is never asserted.
- RUN with stop=1: go to IDLE next cycle with no done pulse.
  - A handshake in the same cycle counts as a transfer.
  - The count does not advance.
- DONE → IDLE unconditionally.
- start outside IDLE is ignored. start and stop together in IDLE: stop wins and the block stays IDLE.
- Arithmetic is modulo 2^WIDTH.
  - Because the bounds are 0 and limit, the count never leaves [0, limit].
  - limit = 2^WIDTH−1 exercises the natural wrap.
- limit = 0 produces a single code 0, then done (or a repeated 0 if cont=1).
- Configuration inputs are ignored after start is accepted. Changing them mid-run has no effect.
- Reset values: state IDLE, count 0, out_valid 0, out_bin 0, out_gray 0, busy 0, done 0.
- Reset mid-run returns immediately to these values. No done pulse is produced.

## Timing
- out_bin, out_gray, out_valid, busy and done are all registered. out_gray is computed from the next-count value and registered in the same edge as out_bin, so the pair is always coherent.
- Start accepted at edge N: out_valid=1 with the first code from cycle N+1.
- Handshake at edge M: the next code is visible at M+1. Full throughput is one code per cycle with out_ready held high.
- While out_valid && !out_ready, out_bin and out_gray hold stable.
- Final handshake at edge M (cont=0):
  - Cycle M+1: DONE, done=1, out_valid=0, busy=0.
  - Cycle M+2: IDLE.
  - The earliest next start edge is M+2; its first code appears at M+3.
- stop sampled at edge S: out_valid=0 and busy=0 from S+1.
- out_valid never drops without a handshake except on stop or reset.

## Structure
- Shared package gray_seq_pkg:
  - State enum {IDLE, RUN, DONE}.
  - Default WIDTH constant.
  - bin2gray function, also usable by the existing datapath.
- One natural sub-module: gray_seq_step. It is combinational: current count, latched mode and limit → next count, plus an end-value flag.
- FSM, config latches and output registers live in the top level.

## Test plan
- Reset held 100 ns, then released, no start → all outputs 0 and state IDLE.
- Up, limit=5, cont=0, out_ready=1:
  - Binary codes 0..5 on consecutive cycles.
  - Gray codes 0000, 0001, 0011, 0010, 0110, 0111.
  - done=1 for exactly one cycle after the 6th transfer.
- Down, limit=3, out_ready toggling 1/0:
  - Codes 3, 2, 1, 0; gray 0010, 0011, 0001, 0000.
  - Each code held stable while out_ready=0.
  - Exactly 4 transfers, then done.
- Up, cont=1, limit=15:
  - Observe 15 (gray 1000) → 0 (gray 0000) wrap.
  - Assert stop mid-run → out_valid=0 next cycle, no done.
- limit=0, cont=0 → single transfer of 0/0000, then done.
- Corner cases:
  - start during RUN → ignored.
  - start and stop together in IDLE → stays IDLE.
  - rst low at the 3rd code → all outputs 0 immediately.
  - A fresh start after reset begins again at code 0.
